pgm_prot_cmd_master: RTL and testbench
======================================

# pgm_prot_cmd_master

Bus-initiator side of the PGM protection register interface. It takes one command request, writes three data words and the command word into the IGS027A protection responder, and polls the responder's status until the done bit is set. It then reads the three data words back and returns them as a single response. It sits between a command source (boot/test sequencer or debug bridge) and the responder's `addr/din/dout/we/re/dtack_n` port, and drives that port exactly as the 68k would.

## Interface
- `BUS_TO`, default 16: cycles to wait for `dtack_n` low after a strobe before aborting (≥1).
- `POLL_MAX`, default 256: maximum number of status reads before aborting (≥1).
- `POLL_GAP`, default 0: idle cycles between a not-done status read and the next poll strobe.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: command request valid.
- `req_ready` out 1: high exactly in IDLE.
- `req_cmd` in 16: command word.
- `req_d0`, `req_d1`, `req_d2` in 16 each: data words.
- `rsp_valid` out 1: response valid; held until accepted.
- `rsp_ready` in 1: response accept.
- `rsp_status` out 2: 0 = OK, 1 = bus timeout, 2 = poll timeout.
- `rsp_d0`, `rsp_d1`, `rsp_d2` out 16 each: read-back data words.
- `bus_addr` out 4: register index. 0 = command (write) / status (read); 1..3 = data 0..2.
- `bus_dout` out 16: write data.
- `bus_din` in 16: read data; valid in the cycle `dtack_n` is low.
- `bus_we`, `bus_re` out 1 each: one-cycle strobes, never both high.
- `bus_dtack_n` in 1: responder acknowledge, active-low.

## Operation
- States:
  - IDLE
  - WR_DATA (index 0..2)
  - WR_CMD
  - POLL
  - GAP
  - RD_DATA (index 0..2)
  - RESP
- IDLE:
  - On `req_valid && req_ready`, latch `cmd` and `d0..d2`, clear the response registers to 0, and go to WR_DATA(0).
- Bus access sub-cycle, used by every access state:
  - ISSUE: drive `bus_addr`, `bus_dout` and one strobe for exactly one cycle.
  - WAIT: strobes low; count cycles.
  - `bus_dtack_n` low completes the access.
  - If the count reaches `BUS_TO` with no acknowledge: `rsp_status`=1, go to RESP.
  - Acknowledge in the same cycle the count expires counts as success.
- Access sequence:
  - WR_DATA(i) writes `d_i` to address i+1, for i = 0, 1, 2.
  - WR_CMD writes `cmd` to address 0.
  - POLL reads address 0. If `bus_din[0]`=1, go to RD_DATA(0).
  - If `bus_din[0]`=0, increment the poll count. At `POLL_MAX`: `rsp_status`=2, go to RESP. Otherwise go to GAP for `POLL_GAP` cycles, then POLL. GAP is skipped when `POLL_GAP`=0.
  - RD_DATA(i) reads address i+1 into `rsp_d_i`.
  - RESP follows RD_DATA(2) with `rsp_status`=0.
- RESP:
  - `rsp_valid`=1 with all `rsp_*` stable.
  - On `rsp_ready`, go to IDLE.
  - Words not read before an abort stay 0.
- `bus_dtack_n` low outside WAIT is ignored.
- Status bit 0 is sticky in the responder. The block does not clear or pre-check it.

## Timing
- Reset values (asserted asynchronously, immediately on `reset_n` low):
  - state IDLE, so `req_ready`=1.
  - `rsp_valid`=0, `rsp_status`=0, `rsp_d*`=0.
  - `bus_addr`=0, `bus_dout`=0, `bus_we`=0, `bus_re`=0.
  - Poll and timeout counters 0.
- Reset mid-transaction drops the strobe and the pending response. No further bus access occurs after release until a new request.
- Per-access cost, with the acknowledge arriving the cycle after the strobe: 2 cycles. The strobe is in cycle n, the acknowledge is sampled at the end of cycle n+1, and the next strobe is in cycle n+2.
- Request accepted at edge E; cycle 0 is the cycle after E:
  - Write strobes in cycles 0, 2, 4, 6 (the command write is cycle 6).
  - First poll strobe in cycle 8.
  - Read strobes in cycles 10, 12, 14.
  - `rsp_valid` rises in cycle 16 when the first poll reads done.
- Each failed poll adds 2 + `POLL_GAP` cycles.
- `req_ready` is 0 from cycle 0 until the cycle after the `rsp_valid && rsp_ready` edge.

## Structure
- Package `pgm_prot_pkg`:
  - Address constants `PROT_ADDR_CMD`=0, `PROT_ADDR_D0`..`PROT_ADDR_D2`=1..3.
  - `PROT_STAT_DONE`=0.
  - Status code enum `prot_rsp_e` (OK, BUS_TO, POLL_TO).
  - Top state enum.
- Sub-module `pgm_prot_bus_xfer`:
  - Inputs: start, rw, addr, wdata.
  - Outputs: done, timeout, rdata.
  - Contains the ISSUE/WAIT sub-FSM and the `BUS_TO` counter.
- The top level sequences its access states over this sub-module.

## Test plan
- Nominal: cmd 0x0011, d0..d2 = 0x1111/0x2222/0x3333, responder model → `rsp_valid` in cycle 16 with d0=0x55AA, d1=0xAA55, d2=0x3333, status 0. Bus trace shows 4 writes at addresses 1, 2, 3, 0 and reads at 0, 1, 2, 3.
- Bus timeout: responder never acknowledges address 2 → exactly `BUS_TO` (16) wait cycles, no further strobes, status 1, `rsp_d*`=0.
- Poll timeout: status stuck at 0, `POLL_MAX`=4, `POLL_GAP`=3 → exactly 4 status reads spaced 5 cycles apart, then status 2.
- Acknowledge exactly at the `BUS_TO` boundary → treated as success, sequence continues.
- Backpressure: `rsp_ready` low for 10 cycles → `rsp_*` stable, `req_ready`=0, no bus strobes. Accept → IDLE next cycle.
- Reset during POLL (`reset_n` low mid-WAIT) → `bus_re` and `rsp_valid` are 0 in the same cycle. After release, a new request completes normally in 16 cycles.

Source files
------------

// File: rtl/pgm_prot_pkg.sv
// Shared constants and types for the PGM protection-register command master.
package pgm_prot_pkg;

    localparam logic [3:0] PROT_ADDR_CMD = 4'd0;
    localparam logic [3:0] PROT_ADDR_D0  = 4'd1;
    localparam logic [3:0] PROT_ADDR_D1  = 4'd2;
    localparam logic [3:0] PROT_ADDR_D2  = 4'd3;

    localparam int PROT_STAT_DONE = 0;

    typedef enum logic [1:0] {
        PROT_RSP_OK      = 2'd0,
        PROT_RSP_BUS_TO  = 2'd1,
        PROT_RSP_POLL_TO = 2'd2
    } prot_rsp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_CMD,
        ST_POLL,
        ST_GAP,
        ST_RD_DATA,
        ST_RESP
    } prot_state_e;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_ISSUE,
        XF_WAIT
    } xfer_state_e;

    // Register index of data word idx (0..2).
    function automatic logic [3:0] data_addr(input logic [1:0] idx);
        return PROT_ADDR_D0 + {2'b00, idx};
    endfunction

endpackage

// File: rtl/pgm_prot_bus_xfer.sv
// One responder bus access: a single-cycle strobe, then wait for dtack_n
// low for at most BUS_TO cycles.
module pgm_prot_bus_xfer
    import pgm_prot_pkg::*;
#(
    parameter int BUS_TO = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        rw,
    input  logic [3:0]  addr,
    input  logic [15:0] wdata,
    output logic        done,
    output logic        timeout,
    output logic [15:0] rdata,
    output logic [3:0]  bus_addr,
    output logic [15:0] bus_dout,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [15:0] bus_din,
    input  logic        bus_dtack_n
);

    localparam int CNT_W = $clog2(BUS_TO + 1);

    xfer_state_e      state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             rw_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= XF_IDLE;
            wait_cnt <= '0;
            rw_q     <= 1'b0;
            bus_addr <= '0;
            bus_dout <= '0;
        end else begin
            state <= state_nxt;
            if (state == XF_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (start) begin
                rw_q     <= rw;
                bus_addr <= addr;
                bus_dout <= wdata;
            end
        end
    end

    // An acknowledge in the last allowed wait cycle wins over the timeout.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            XF_IDLE:  state_nxt = XF_IDLE;
            XF_ISSUE: state_nxt = XF_WAIT;
            XF_WAIT: begin
                if (!bus_dtack_n) begin
                    done      = 1'b1;
                    state_nxt = XF_IDLE;
                end else if (wait_cnt == CNT_W'(BUS_TO - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = XF_IDLE;
                end
            end
            default: state_nxt = XF_IDLE;
        endcase
        if (start) begin
            state_nxt = XF_ISSUE;
        end
    end

    assign bus_we = (state == XF_ISSUE) && !rw_q;
    assign bus_re = (state == XF_ISSUE) && rw_q;
    assign rdata  = bus_din;

endmodule

// File: rtl/pgm_prot_cmd_master.sv
// Command master for the IGS027A protection responder: write d0..d2 and the
// command, poll status bit 0, read d0..d2 back and return one response.
module pgm_prot_cmd_master
    import pgm_prot_pkg::*;
#(
    parameter int BUS_TO   = 16,
    parameter int POLL_MAX = 256,
    parameter int POLL_GAP = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_cmd,
    input  logic [15:0] req_d0,
    input  logic [15:0] req_d1,
    input  logic [15:0] req_d2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_status,
    output logic [15:0] rsp_d0,
    output logic [15:0] rsp_d1,
    output logic [15:0] rsp_d2,
    output logic [3:0]  bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        bus_we,
    output logic        bus_re,
    input  logic        bus_dtack_n
);

    localparam int POLL_W = $clog2(POLL_MAX + 1);
    localparam int GAP_W  = $clog2(POLL_GAP + 2);

    prot_state_e       state, state_nxt;
    logic [1:0]        idx, idx_nxt;
    logic [POLL_W-1:0] poll_cnt, poll_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    prot_rsp_e         status_q, status_nxt;
    logic [15:0]       rsp_w0, rsp_w1, rsp_w2;
    logic [15:0]       rsp_w0_nxt, rsp_w1_nxt, rsp_w2_nxt;
    logic [15:0]       cmd_q, d0_q, d1_q, d2_q;
    logic              load_req;

    logic              xfer_start, xfer_rw, xfer_done, xfer_timeout;
    logic [3:0]        xfer_addr;
    logic [15:0]       xfer_wdata, xfer_rdata;

    function automatic logic [15:0] pick_word(input logic [1:0] i, input logic [15:0] w0,
                                              input logic [15:0] w1, input logic [15:0] w2);
        case (i)
            2'd0:    return w0;
            2'd1:    return w1;
            default: return w2;
        endcase
    endfunction

    pgm_prot_bus_xfer #(
        .BUS_TO (BUS_TO)
    ) u_xfer (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (xfer_start),
        .rw          (xfer_rw),
        .addr        (xfer_addr),
        .wdata       (xfer_wdata),
        .done        (xfer_done),
        .timeout     (xfer_timeout),
        .rdata       (xfer_rdata),
        .bus_addr    (bus_addr),
        .bus_dout    (bus_dout),
        .bus_we      (bus_we),
        .bus_re      (bus_re),
        .bus_din     (bus_din),
        .bus_dtack_n (bus_dtack_n)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            status_q <= PROT_RSP_OK;
            rsp_w0   <= '0;
            rsp_w1   <= '0;
            rsp_w2   <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            poll_cnt <= poll_nxt;
            gap_cnt  <= gap_nxt;
            status_q <= status_nxt;
            rsp_w0   <= rsp_w0_nxt;
            rsp_w1   <= rsp_w1_nxt;
            rsp_w2   <= rsp_w2_nxt;
        end
    end

    // Request words are only meaningful after a load, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load_req) begin
            cmd_q <= req_cmd;
            d0_q  <= req_d0;
            d1_q  <= req_d1;
            d2_q  <= req_d2;
        end
    end

    // Each completing access launches the next one in the same cycle, so
    // back-to-back accesses cost strobe + acknowledge cycles only.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        poll_nxt   = poll_cnt;
        gap_nxt    = gap_cnt;
        status_nxt = status_q;
        rsp_w0_nxt = rsp_w0;
        rsp_w1_nxt = rsp_w1;
        rsp_w2_nxt = rsp_w2;
        load_req   = 1'b0;
        xfer_start = 1'b0;
        xfer_rw    = 1'b0;
        xfer_addr  = PROT_ADDR_CMD;
        xfer_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    load_req   = 1'b1;
                    rsp_w0_nxt = '0;
                    rsp_w1_nxt = '0;
                    rsp_w2_nxt = '0;
                    status_nxt = PROT_RSP_OK;
                    poll_nxt   = '0;
                    gap_nxt    = '0;
                    idx_nxt    = 2'd0;
                    xfer_start = 1'b1;
                    xfer_addr  = PROT_ADDR_D0;
                    xfer_wdata = req_d0;
                    state_nxt  = ST_WR_DATA;
                end
            end
            ST_WR_DATA, ST_WR_CMD, ST_POLL, ST_RD_DATA: begin
                if (xfer_timeout) begin
                    status_nxt = PROT_RSP_BUS_TO;
                    state_nxt  = ST_RESP;
                end else if (xfer_done) begin
                    case (state)
                        ST_WR_DATA: begin
                            xfer_start = 1'b1;
                            if (idx == 2'd2) begin
                                xfer_addr  = PROT_ADDR_CMD;
                                xfer_wdata = cmd_q;
                                state_nxt  = ST_WR_CMD;
                            end else begin
                                idx_nxt    = idx + 2'd1;
                                xfer_addr  = data_addr(idx + 2'd1);
                                xfer_wdata = pick_word(idx + 2'd1, d0_q, d1_q, d2_q);
                            end
                        end
                        ST_WR_CMD: begin
                            xfer_start = 1'b1;
                            xfer_rw    = 1'b1;
                            xfer_addr  = PROT_ADDR_CMD;
                            state_nxt  = ST_POLL;
                        end
                        ST_POLL: begin
                            if (xfer_rdata[PROT_STAT_DONE]) begin
                                xfer_start = 1'b1;
                                xfer_rw    = 1'b1;
                                xfer_addr  = PROT_ADDR_D0;
                                idx_nxt    = 2'd0;
                                state_nxt  = ST_RD_DATA;
                            end else begin
                                poll_nxt = poll_cnt + 1'b1;
                                if (poll_cnt == POLL_W'(POLL_MAX - 1)) begin
                                    status_nxt = PROT_RSP_POLL_TO;
                                    state_nxt  = ST_RESP;
                                end else if (POLL_GAP == 0) begin
                                    xfer_start = 1'b1;
                                    xfer_rw    = 1'b1;
                                    xfer_addr  = PROT_ADDR_CMD;
                                end else begin
                                    gap_nxt   = '0;
                                    state_nxt = ST_GAP;
                                end
                            end
                        end
                        default: begin
                            case (idx)
                                2'd0:    rsp_w0_nxt = xfer_rdata;
                                2'd1:    rsp_w1_nxt = xfer_rdata;
                                default: rsp_w2_nxt = xfer_rdata;
                            endcase
                            if (idx == 2'd2) begin
                                state_nxt = ST_RESP;
                            end else begin
                                idx_nxt    = idx + 2'd1;
                                xfer_start = 1'b1;
                                xfer_rw    = 1'b1;
                                xfer_addr  = data_addr(idx + 2'd1);
                            end
                        end
                    endcase
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                    xfer_start = 1'b1;
                    xfer_rw    = 1'b1;
                    xfer_addr  = PROT_ADDR_CMD;
                    state_nxt  = ST_POLL;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign req_ready  = (state == ST_IDLE);
    assign rsp_valid  = (state == ST_RESP);
    assign rsp_status = status_q;
    assign rsp_d0     = rsp_w0;
    assign rsp_d1     = rsp_w1;
    assign rsp_d2     = rsp_w2;

endmodule

// File: tb/tb_pgm_prot_cmd_master.sv
// Bench for pgm_prot_cmd_master: randomized commands against a responder
// model, with responses and bus traces predicted from cycle arithmetic.
`timescale 1ns/1ps
module tb_pgm_prot_cmd_master;

    localparam int BUS_TO   = 16;
    localparam int POLL_MAX = 4;
    localparam int POLL_GAP = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_cmd = '0, req_d0 = '0, req_d1 = '0, req_d2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_d0, rsp_d1, rsp_d2;
    logic [3:0]  bus_addr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din = '0;
    logic        bus_we, bus_re;
    logic        bus_dtack_n = 1'b1;

    always #5 clk = ~clk;

    pgm_prot_cmd_master #(
        .BUS_TO   (BUS_TO),
        .POLL_MAX (POLL_MAX),
        .POLL_GAP (POLL_GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_d0      (req_d0),
        .req_d1      (req_d1),
        .req_d2      (req_d2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_status  (rsp_status),
        .rsp_d0      (rsp_d0),
        .rsp_d1      (rsp_d1),
        .rsp_d2      (rsp_d2),
        .bus_addr    (bus_addr),
        .bus_dout    (bus_dout),
        .bus_din     (bus_din),
        .bus_we      (bus_we),
        .bus_re      (bus_re),
        .bus_dtack_n (bus_dtack_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder behaviour: results appear when the first status read after
    // busy_cfg not-done reads finds the command finished.
    function automatic logic [15:0] result_word(input logic [15:0] cmd, input int i,
                                                input logic [15:0] d);
        if (cmd == 16'h0011) begin
            if (i == 0) return 16'h55AA;
            if (i == 1) return 16'hAA55;
            return d;
        end
        return d + cmd;
    endfunction

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
        int          cyc;
    } acc_t;

    acc_t        trace[$];
    logic [15:0] regs[4];
    logic        done_flag = 1'b0;
    int          busy_left = 0;
    int          busy_cfg = 0;
    int          rsp_dly = 1;
    int          never_addr = -1;
    int          both_strobes = 0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic        pend_we = 1'b0;
    logic [3:0]  pend_addr = '0;
    logic [15:0] pend_data = '0;

    always @(negedge clk) begin
        logic [15:0] junk;
        junk        = 16'($urandom);
        bus_dtack_n = 1'b1;
        bus_din     = junk;
        if (!reset_n) begin
            pend = 1'b0;
        end else if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend        = 1'b0;
                bus_dtack_n = 1'b0;
                if (pend_we) begin
                    regs[pend_addr[1:0]] = pend_data;
                    if (pend_addr == 4'd0) begin
                        done_flag = 1'b0;
                        busy_left = busy_cfg;
                    end
                end else if (pend_addr == 4'd0) begin
                    if (!done_flag) begin
                        if (busy_left == 0) begin
                            done_flag = 1'b1;
                            regs[1] = result_word(regs[0], 0, regs[1]);
                            regs[2] = result_word(regs[0], 1, regs[2]);
                            regs[3] = result_word(regs[0], 2, regs[3]);
                        end else begin
                            busy_left--;
                        end
                    end
                    bus_din = {junk[15:1], done_flag};
                end else begin
                    bus_din = regs[pend_addr[1:0]];
                end
            end
        end else if ($urandom_range(9) == 0) begin
            bus_dtack_n = 1'b0;
        end
        if (bus_we || bus_re) begin
            if (bus_we && bus_re) both_strobes++;
            trace.push_back('{we: bus_we, addr: bus_addr, data: bus_dout, cyc: cyc});
            pend      = 1'b1;
            pend_we   = bus_we;
            pend_addr = bus_addr;
            pend_data = bus_dout;
            pend_cnt  = (int'(bus_addr) == never_addr) ? (1 << 30) : rsp_dly;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_txn(input string tag, input logic [15:0] cmd, input logic [15:0] d0,
                           input logic [15:0] d1, input logic [15:0] d2, input int dly,
                           input int busy, input int nev, input int hold);
        acc_t        exp_q[$];
        logic [15:0] ew[3];
        logic [15:0] wd[4];
        logic [3:0]  wa[4];
        int          t, exp_lat, exp_status, polls, t0, lat, n_tr;
        logic        seen, stable;
        logic [1:0]  s_st;
        logic [15:0] s0, s1, s2;

        wd = '{d0, d1, d2, cmd};
        wa = '{4'd1, 4'd2, 4'd3, 4'd0};
        ew = '{16'h0, 16'h0, 16'h0};
        t  = 0;
        if (nev >= 1 && nev <= 3) begin
            for (int i = 0; i < nev; i++) begin
                exp_q.push_back('{we: 1'b1, addr: wa[i], data: wd[i], cyc: t});
                if (i < nev - 1) t += 1 + dly;
            end
            exp_lat    = t + 1 + BUS_TO;
            exp_status = 1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back('{we: 1'b1, addr: wa[i], data: wd[i], cyc: t});
                t += 1 + dly;
            end
            polls = (busy >= POLL_MAX) ? POLL_MAX : busy + 1;
            for (int p = 0; p < polls; p++) begin
                exp_q.push_back('{we: 1'b0, addr: 4'd0, data: 16'h0, cyc: t});
                t += 1 + dly;
                if (p < polls - 1) t += POLL_GAP;
            end
            if (busy >= POLL_MAX) begin
                exp_status = 2;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    exp_q.push_back('{we: 1'b0, addr: wa[i], data: 16'h0, cyc: t});
                    t += 1 + dly;
                    ew[i] = result_word(cmd, i, wd[i]);
                end
                exp_status = 0;
            end
            exp_lat = t;
        end

        rsp_dly    = dly;
        busy_cfg   = busy;
        never_addr = nev;
        tick();
        trace.delete();
        check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_d0    = d0;
        req_d1    = d1;
        req_d2    = d2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_cmd   = 16'($urandom);
        req_d0    = 16'($urandom);
        req_d1    = 16'($urandom);
        req_d2    = 16'($urandom);
        t0 = cyc;

        seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " rsp_valid seen"}, 32'(seen), 32'd1);
        if (!seen) return;
        lat = cyc - t0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " status"}, 32'(rsp_status), 32'(exp_status));
        check({tag, " d0"}, 32'(rsp_d0), 32'(ew[0]));
        check({tag, " d1"}, 32'(rsp_d1), 32'(ew[1]));
        check({tag, " d2"}, 32'(rsp_d2), 32'(ew[2]));
        check({tag, " req_ready busy"}, 32'(req_ready), 32'd0);

        n_tr   = trace.size();
        s_st   = rsp_status;
        s0     = rsp_d0;
        s1     = rsp_d1;
        s2     = rsp_d2;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            tick();
            if (!rsp_valid || req_ready || rsp_status !== s_st || rsp_d0 !== s0 ||
                rsp_d1 !== s1 || rsp_d2 !== s2) stable = 1'b0;
        end
        if (hold > 0) begin
            check({tag, " hold stable"}, 32'(stable), 32'd1);
            check({tag, " hold no strobes"}, 32'(trace.size()), 32'(n_tr));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, " req_ready after accept"}, 32'(req_ready), 32'd1);
        check({tag, " rsp_valid after accept"}, 32'(rsp_valid), 32'd0);

        check({tag, " access count"}, 32'(trace.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < trace.size(); i++) begin
            check($sformatf("%s acc%0d we", tag, i), 32'(trace[i].we), 32'(exp_q[i].we));
            check($sformatf("%s acc%0d addr", tag, i), 32'(trace[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s acc%0d cycle", tag, i), 32'(trace[i].cyc - t0), 32'(exp_q[i].cyc));
            if (exp_q[i].we)
                check($sformatf("%s acc%0d data", tag, i), 32'(trace[i].data), 32'(exp_q[i].data));
        end
    endtask

    task automatic reset_in_poll();
        logic hit;
        rsp_dly    = 1;
        busy_cfg   = 1000;
        never_addr = -1;
        tick();
        req_valid = 1'b1;
        req_cmd   = 16'h0042;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus_re && bus_addr == 4'd0) begin
                hit = 1'b1;
                break;
            end
        end
        check("rst poll strobe seen", 32'(hit), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst bus_re", 32'(bus_re), 32'd0);
        check("rst bus_we", 32'(bus_we), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        trace.delete();
        repeat (5) tick();
        check("rst no strobes after release", 32'(trace.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] c, a, b, e;
        int          dl, bz, nv, hd;
        repeat (3) @(negedge clk);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_status", 32'(rsp_status), 32'd0);
        check("reset rsp_d", 32'({rsp_d0, rsp_d1} | 32'(rsp_d2)), 32'd0);
        check("reset bus_addr", 32'(bus_addr), 32'd0);
        check("reset bus_dout", 32'(bus_dout), 32'd0);
        check("reset strobes", 32'({bus_we, bus_re}), 32'd0);
        reset_n = 1'b1;

        run_txn("nominal", 16'h0011, 16'h1111, 16'h2222, 16'h3333, 1, 0, -1, 0);
        run_txn("bus_to", 16'h0022, 16'h1234, 16'h5678, 16'h9ABC, 1, 0, 2, 0);
        run_txn("poll_to", 16'h0033, 16'hAAAA, 16'hBBBB, 16'hCCCC, 1, 100000, -1, 0);
        run_txn("ack_at_limit", 16'h0044, 16'h0101, 16'h0202, 16'h0303, BUS_TO, 0, -1, 0);
        run_txn("backpressure", 16'h0055, 16'hF00D, 16'hBEEF, 16'hCAFE, 1, 1, -1, 10);
        reset_in_poll();
        run_txn("after_reset", 16'h0011, 16'h1111, 16'h2222, 16'h3333, 1, 0, -1, 0);

        for (int n = 0; n < 10; n++) begin
            c  = 16'($urandom);
            a  = 16'($urandom);
            b  = 16'($urandom);
            e  = 16'($urandom);
            dl = int'($urandom_range(3, 1));
            bz = int'($urandom_range(5, 0));
            nv = ($urandom_range(5) == 0) ? int'($urandom_range(3, 1)) : -1;
            hd = int'($urandom_range(3, 0));
            run_txn($sformatf("rand%0d", n), c, a, b, e, dl, bz, nv, hd);
        end

        check("never both strobes", 32'(both_strobes), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
